vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// Produces pixel/line counters plus registered sync, blank and frame
// markers for a raster display. All outputs are flops loaded from the
// next-state counter values, so every output describes the same pixel
// as the DrawX/DrawY presented alongside it.
//
// Ports
//   vga_clk      in   pixel clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   DrawX[9:0]   out  current column (0..H_TOTAL-1)
//   DrawY[9:0]   out  current row    (0..V_TOTAL-1)
//   hs, vs       out  horizontal / vertical sync, active-low
//   blank        out  1 = visible pixel, 0 = blanked
//   line_end     out  pulse on the last pixel of every line
//   frame_start  out  pulse at (0,0) of every frame after the first
//   frame_count  out  frames completed since reset, wraps at 256
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic       line_end_q, line_end_d, frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       h_wrap, f_wrap;

  always_comb begin
    h_wrap = (x_q == H_LAST);
    f_wrap = h_wrap && (y_q == V_LAST);

    x_d = h_wrap ? 10'd0 : x_q + 10'd1;
    y_d = y_q;
    if (h_wrap) y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;

    // Decode on the next-state counters so the registered flags line up
    // with the registered counters on the same cycle.
    hs_d          = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d          = !((y_d >= VS_START) && (y_d < VS_END));
    blank_d       = (x_d < H_VIS) && (y_d < V_VIS);
    line_end_d    = (x_d == H_LAST);
    // Only a real frame wrap produces a start pulse; leaving reset lands
    // on (0,0) without one.
    frame_start_d = f_wrap;
    frame_count_d = frame_count_q + {7'd0, f_wrap};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster:
//   H: 8 active, 2 fp, 3 sync, 2 bp -> 15 pixels/line, hs low on x 10..12
//   V: 6 active, 1 fp, 2 sync, 1 bp -> 10 lines/frame, vs low on y 7..8
//   one frame = 150 cycles
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, line_end, frame_start;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .hs(hs), .vs(vs), .blank(blank), .line_end(line_end),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  // ---------------- directed vector table ----------------
  typedef struct {
    int       cyc;   // rising edges since reset release
    int       x, y;
    bit       hs, vs, bl, le, fs;
    int       fc;
  } vec_t;

  vec_t vecs[16];

  task automatic cmp(input string name, input int ax, ay, input bit ahs, avs, abl, ale, afs,
                     input int afc, input int ex, ey, input bit ehs, evs, ebl, ele, efs, input int efc);
    checks++;
    if (ax != ex || ay != ey || ahs != ehs || avs != evs || abl != ebl || ale != ele ||
        afs != efs || afc != efc) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d hs=%0b vs=%0b blank=%0b le=%0b fs=%0b fc=%0d, want x=%0d y=%0d hs=%0b vs=%0b blank=%0b le=%0b fs=%0b fc=%0d",
               name, ax, ay, ahs, avs, abl, ale, afs, afc, ex, ey, ehs, evs, ebl, ele, efs, efc);
    end
  endtask

  task automatic cmp_vec(input string name, input vec_t v);
    cmp(name, int'(DrawX), int'(DrawY), hs, vs, blank, line_end, frame_start, int'(frame_count),
        v.x, v.y, v.hs, v.vs, v.bl, v.le, v.fs, v.fc);
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- independent reference model ----------------
  int mx, my, mfc;
  bit mfs;
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mx <= 0; my <= 0; mfc <= 0; mfs <= 1'b0;
    end else if (mx == 14) begin
      mx <= 0;
      if (my == 9) begin my <= 0; mfs <= 1'b1; mfc <= (mfc + 1) % 256; end
      else begin my <= my + 1; mfs <= 1'b0; end
    end else begin
      mx <= mx + 1; mfs <= 1'b0;
    end
  end

  int cont_fails = 0;
  always @(negedge vga_clk) begin
    if (reset_n) begin
      checks++;
      if (int'(DrawX) != mx || int'(DrawY) != my ||
          hs != !(mx >= 10 && mx < 13) || vs != !(my >= 7 && my < 9) ||
          blank != (mx < 8 && my < 6) || line_end != (mx == 14) ||
          frame_start != mfs || int'(frame_count) != mfc) begin
        errors++;
        cont_fails++;
        if (cont_fails <= 10)
          $display("FAIL continuous at x=%0d y=%0d: got hs=%0b vs=%0b blank=%0b le=%0b fs=%0b fc=%0d dx=%0d dy=%0d",
                   mx, my, hs, vs, blank, line_end, frame_start, frame_count, DrawX, DrawY);
      end
    end
  end

  // ---------------- frame_start pulse monitor ----------------
  int ncyc;
  always @(posedge vga_clk or negedge reset_n)
    if (!reset_n) ncyc <= 0; else ncyc <= ncyc + 1;

  int pulses = 0;
  int prev_pulse = 0;
  bit have_prev = 1'b0;
  always @(negedge vga_clk) begin
    if (!reset_n) have_prev = 1'b0;
    else if (frame_start) begin
      pulses++;
      if (have_prev) cmp_int("frame_start spacing", ncyc - prev_pulse, 150);
      prev_pulse = ncyc;
      have_prev  = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  int n;
  int p0;

  task automatic step_to(input int cyc);
    repeat (cyc - n) @(posedge vga_clk);
    n = cyc;
    #2;
  endtask

  vec_t rv;

  initial begin
    //          cyc   x  y  hs vs bl le fs fc
    vecs[0]  = '{  0,  0, 0, 1, 1, 1, 0, 0, 0};
    vecs[1]  = '{  1,  1, 0, 1, 1, 1, 0, 0, 0};
    vecs[2]  = '{  7,  7, 0, 1, 1, 1, 0, 0, 0};
    vecs[3]  = '{  8,  8, 0, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{ 10, 10, 0, 0, 1, 0, 0, 0, 0};
    vecs[5]  = '{ 12, 12, 0, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{ 13, 13, 0, 1, 1, 0, 0, 0, 0};
    vecs[7]  = '{ 14, 14, 0, 1, 1, 0, 1, 0, 0};
    vecs[8]  = '{ 15,  0, 1, 1, 1, 1, 0, 0, 0};
    vecs[9]  = '{ 90,  0, 6, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{105,  0, 7, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{134, 14, 8, 1, 0, 0, 1, 0, 0};
    vecs[12] = '{135,  0, 9, 1, 1, 0, 0, 0, 0};
    vecs[13] = '{149, 14, 9, 1, 1, 0, 1, 0, 0};
    vecs[14] = '{150,  0, 0, 1, 1, 1, 0, 1, 1};
    vecs[15] = '{151,  1, 0, 1, 1, 1, 0, 0, 1};
    rv       = '{  0,  0, 0, 1, 1, 1, 0, 0, 0};

    // Reset state while held.
    #12;
    cmp_vec("reset hold", rv);

    @(negedge vga_clk); #1;
    reset_n = 1'b1;
    n = 0;

    foreach (vecs[i]) begin
      step_to(vecs[i].cyc);
      cmp_vec($sformatf("vec%0d cyc%0d", i, vecs[i].cyc), vecs[i]);
    end

    // 256 frames: counter wraps back to 0 on the 256th start pulse.
    step_to(256 * 150);
    cmp("frame 256 wrap", int'(DrawX), int'(DrawY), hs, vs, blank, line_end, frame_start,
        int'(frame_count), 0, 0, 1, 1, 1, 0, 1, 0);
    @(negedge vga_clk); #1;
    cmp_int("frame_start pulses in 256 frames", pulses, 256);

    // Park mid-frame at x=12, y=4 with frame_count=1, then reset between edges.
    step_to(257 * 150 + 4 * 15 + 12);
    cmp("pre-reset position", int'(DrawX), int'(DrawY), hs, vs, blank, line_end, frame_start,
        int'(frame_count), 12, 4, 0, 1, 0, 0, 0, 1);
    #1;
    reset_n = 1'b0;
    #1;
    cmp_vec("async reset immediate", rv);
    repeat (3) @(posedge vga_clk);
    #1;
    cmp_vec("reset held across edges", rv);

    @(negedge vga_clk); #1;
    p0 = pulses;
    reset_n = 1'b1;
    n = 0;
    step_to(1);
    cmp("post-reset first edge", int'(DrawX), int'(DrawY), hs, vs, blank, line_end, frame_start,
        int'(frame_count), 1, 0, 1, 1, 1, 0, 0, 0);
    step_to(149);
    @(negedge vga_clk); #1;
    cmp_int("no spurious frame_start after reset", pulses, p0);
    step_to(150);
    cmp("first frame after reset", int'(DrawX), int'(DrawY), hs, vs, blank, line_end, frame_start,
        int'(frame_count), 0, 0, 1, 1, 1, 0, 1, 1);

    step_to(155);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
